// File: rtl/register_dump_writer_pkg.sv
// Shared definitions for the register dump writer.
//   - FSM state encoding (state_t, STATE_W)
//   - ASCII constants used by the hex renderer
//   - Screen geometry shared with ascii_master_controller
package register_dump_writer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SET_REG  = 3'd1,
        ST_WAIT_REG = 3'd2,
        ST_LATCH    = 3'd3,
        ST_EMIT     = 3'd4,
        ST_GAP      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // Screen geometry of the ASCII VGA controller.
    localparam int COLS       = 80;
    localparam int ADDR_WIDTH = 13;

endpackage

// File: rtl/register_dump_writer_hex_to_ascii.sv
// hex_to_ascii: combinational nibble-to-ASCII renderer (upper-case hex).
// Ports:
//   nibble_i  in   4  value 0..15
//   ascii_o   out  8  '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
module hex_to_ascii
    import register_dump_writer_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'd0, nibble_i};
        end else begin
            ascii_o = ASCII_A + {4'd0, nibble_i - 4'd10};
        end
    end

endmodule

// File: rtl/register_dump_writer.sv
// register_dump_writer: walks every architectural register through the
// register file debug port and writes it to the character screen as
// WORD_SIZE/4 hex digits, one row per register, most significant digit in
// the leftmost column.
// Ports:
//   clk                  in   1           system clock
//   rst                  in   1           asynchronous active-low reset
//   start                in   1           dump request, sampled only in IDLE
//   busy                 out  1           dump in progress
//   done                 out  1           one-cycle completion pulse
//   debug_reg            out  5           register index to register_file
//   debug_reg_out        in   WORD_SIZE   register value (combinational)
//   ascii_write_en       out  1           character write strobe
//   ascii_write_address  out  ADDR_WIDTH  character cell index
//   ascii_input          out  32          {char[7:0], ATTR}
//   state_dbg            out  3           current FSM state
//
// Handshake: a high start seen while IDLE launches one dump; busy rises on the
// next cycle and stays high through DONE; done pulses for exactly the DONE
// cycle. start at any other time is dropped, never queued. A start that is
// still high when the FSM returns to IDLE launches a fresh dump.
module register_dump_writer #(
    parameter int          WORD_SIZE  = 32,
    parameter int          NUM_REGS   = 32,
    parameter int          COLS       = register_dump_writer_pkg::COLS,
    parameter int          ADDR_WIDTH = register_dump_writer_pkg::ADDR_WIDTH,
    parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            debug_reg,
    input  logic [WORD_SIZE-1:0]  debug_reg_out,
    output logic                  ascii_write_en,
    output logic [ADDR_WIDTH-1:0] ascii_write_address,
    output logic [31:0]           ascii_input,
    output logic [2:0]            state_dbg
);

    import register_dump_writer_pkg::*;

    localparam int DIGITS = WORD_SIZE / 4;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS - 1);
    localparam logic [4:0]       LAST_REG   = 5'(NUM_REGS - 1);

    state_t                  state_q, state_d;
    logic [4:0]              reg_idx_q, reg_idx_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [WORD_SIZE-1:0]    word_q, word_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [4:0]              debug_reg_q, debug_reg_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic [7:0]              char_w;

    // Next-state and datapath bookkeeping.
    always_comb begin
        state_d     = state_q;
        reg_idx_d   = reg_idx_q;
        digit_d     = digit_q;
        word_d      = word_q;
        busy_d      = busy_q;
        debug_reg_d = debug_reg_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SET_REG;
                    reg_idx_d = 5'd0;
                    busy_d    = 1'b1;
                end
            end
            ST_SET_REG: begin
                debug_reg_d = reg_idx_q;
                state_d     = ST_WAIT_REG;
            end
            // The register file read is combinational from debug_reg; this
            // cycle lets the registered index settle before sampling.
            ST_WAIT_REG: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                word_d  = debug_reg_out;
                digit_d = '0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                word_d  = word_q << 4;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (digit_q < LAST_DIGIT) begin
                    digit_d = digit_q + DIG_W'(1);
                    state_d = ST_EMIT;
                end else if (reg_idx_q < LAST_REG) begin
                    reg_idx_d = reg_idx_q + 5'd1;
                    state_d   = ST_SET_REG;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The character for the next EMIT always comes from the top nibble of the
    // word as it will stand in that cycle (freshly latched or already shifted).
    hex_to_ascii u_hex (
        .nibble_i (word_d[WORD_SIZE-1 -: 4]),
        .ascii_o  (char_w)
    );

    // Registered write port: loaded on entry to EMIT, held through GAP.
    always_comb begin
        we_d   = 1'b0;
        done_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        if (state_d == ST_EMIT) begin
            we_d   = 1'b1;
            addr_d = ADDR_WIDTH'(reg_idx_q) * ADDR_WIDTH'(COLS)
                   + ADDR_WIDTH'(digit_d);
            data_d = {char_w, ATTR};
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            reg_idx_q   <= 5'd0;
            digit_q     <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            debug_reg_q <= 5'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            reg_idx_q   <= reg_idx_d;
            digit_q     <= digit_d;
            word_q      <= word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            debug_reg_q <= debug_reg_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign debug_reg           = debug_reg_q;
    assign ascii_write_en      = we_q;
    assign ascii_write_address = addr_q;
    assign ascii_input         = data_q;
    assign state_dbg           = state_q;

endmodule
